// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants and the fetch payload type.
package rv32i_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned INST_W   = 32;
  localparam logic [XLEN-1:0]   RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory request/response, redirect in, decode out.
interface rv32i_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  import rv32i_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic [XLEN-1:0]   if_pc_plus4;
  logic              fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_inst, if_pc_plus4, fetch_fault,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_inst, if_pc_plus4, fetch_fault,
    output if_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head word is read straight from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign head_data = mem[rd_ptr];

  // Upstream credit accounting must never let a push land on a full queue.
  always_ff @(posedge clk) begin
    if (rst_n && do_push && !do_pop) assert (count < CW'(DEPTH));
  end
endmodule

// File: rtl/rv32i_fetch_unit.sv
// Decoupled RV32I fetch: credit-limited imem requests, prefetch queue, redirect flush/drop.
module rv32i_fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(rv32i_pkg::RESET_PC),
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               reset,
  rv32i_fetch_unit_if.master bus
);
  import rv32i_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = XLEN + INST_W;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic [XLEN-1:0] rsp_pc, rsp_pc_nxt;
  logic [CW-1:0]   outstanding, out_nxt, out_after_rsp;
  logic [CW-1:0]   drop_cnt, drop_nxt;
  logic [CW-1:0]   q_count;
  logic [CW:0]     credit_used;
  logic            fault_q, fault_nxt;
  logic            req_valid, req_fire;
  logic            if_valid;
  logic            push, pop, flush;
  entry_t          head, push_entry;

  // Queued words plus live (non-dropped) requests must fit in the queue.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding - drop_cnt};
  assign req_valid   = reset && !bus.redirect_valid && !fault_q
                       && (outstanding < MAX_OUT_C) && (credit_used < DEPTH_C);
  assign req_fire    = req_valid && bus.imem_req_ready;
  assign if_valid    = (q_count != '0);
  assign push_entry  = '{pc: rsp_pc, inst: bus.imem_rsp_data};

  always_comb begin
    req_pc_nxt    = req_pc;
    rsp_pc_nxt    = rsp_pc;
    drop_nxt      = drop_cnt;
    fault_nxt     = fault_q;
    push          = 1'b0;
    flush         = 1'b0;
    out_after_rsp = (bus.imem_rsp_valid && (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
    out_nxt       = out_after_rsp + CW'(req_fire);
    pop           = if_valid && bus.if_ready && !bus.redirect_valid;
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      flush      = 1'b1;
      req_pc_nxt = bus.redirect_pc;
      rsp_pc_nxt = bus.redirect_pc;
      drop_nxt   = out_after_rsp;
      fault_nxt  = |bus.redirect_pc[1:0];
    end else begin
      if (req_fire) req_pc_nxt = req_pc + XLEN'(4);
      if (bus.imem_rsp_valid) begin
        if (drop_cnt != '0) begin
          drop_nxt = drop_cnt - 1'b1;
        end else begin
          push       = 1'b1;
          rsp_pc_nxt = rsp_pc + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc      <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fault_q     <= 1'b0;
    end else begin
      req_pc      <= req_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      fault_q     <= fault_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_entry),
    .head_data (head),
    .count     (q_count)
  );

  // Decode-side payload reads as zero whenever nothing is queued.
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_pc;
  assign bus.if_valid       = if_valid;
  assign bus.if_pc          = if_valid ? head.pc : '0;
  assign bus.if_inst        = if_valid ? head.inst : '0;
  assign bus.if_pc_plus4    = if_valid ? head.pc + XLEN'(4) : '0;
  assign bus.fetch_fault    = fault_q;
endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
Decoupled, parametrised instruction-fetch stage for the pipelined RV32I core. It replaces the bare PC register, PC+4 adder and PC-source mux with a request/response instruction-memory interface, a prefetch queue and redirect handling. Its valid/ready output feeds the decode stage. Redirects from execute (branches and jumps) flush the queue and discard in-flight responses.

Parameters:
XLEN, 32, address/data width (instruction fixed 32 bits)
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch queue entries; power of 2, >=2
MAX_OUTSTANDING, 2, max imem requests in flight; 1..DEPTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, >=1 cycle after acceptance, never back-pressured
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  XLEN  new fetch address
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_pc  out  XLEN  PC of if_inst
if_inst  out  32  instruction word
if_pc_plus4  out  XLEN  if_pc+4, for JAL/JALR write-back
fetch_fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Reset (reset=0, async): req_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, fetch_fault=0. All outputs 0 except imem_req_addr=RESET_PC.
- Request issue: imem_req_valid=1 when all hold: !redirect_valid, !fetch_fault, outstanding<MAX_OUTSTANDING, count+(outstanding-drop_cnt)<DEPTH.
  - imem_req_addr=req_pc.
  - On req_valid&req_ready: req_pc+=4 (wraps mod 2^XLEN), outstanding+1.
- Response: every imem_rsp_valid decrements outstanding.
  - drop_cnt>0: discard the word, drop_cnt-1.
  - Otherwise: enqueue {rsp_pc, data}, rsp_pc+=4.
  - The credit rule guarantees space, so responses are never lost. An overflow is an assertion failure.
- Output: head of queue, registered. if_valid=(count!=0); if_pc_plus4=if_pc+4. Pop on if_valid&if_ready.
- Minimum latency: request accepted at t, response at t+L, if_valid at t+L+1. No response-to-output bypass.
- Simultaneous push and pop: count unchanged. Queue full plus pop plus push is legal.
- Redirect (redirect_valid=1, takes priority over everything):
  - Queue flushed. if_valid=0 next cycle; a same-cycle if handshake is void.
  - req_pc and rsp_pc load redirect_pc.
  - drop_cnt = outstanding after this cycle's response, so every in-flight response is dropped.
  - A response arriving in the redirect cycle is discarded.
  - redirect_pc[1:0]!=0: fetch_fault=1 and requests stop. Cleared only by an aligned redirect or reset.
- Back-to-back redirects: each reloads the PCs and recomputes drop_cnt. Counters never underflow.
- Counter widths: $clog2(DEPTH+1) for count/outstanding/drop_cnt.

Decomposition:
- Package rv32i_pkg: XLEN, INST_W=32, RESET_PC default, NOP encoding 32'h0000_0013, fetch_entry_t struct {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO, parametrised WIDTH/DEPTH, with push/pop/flush, count and head-data outputs. Flush has priority over push.
- Control, counters and PC registers live in rv32i_fetch_unit.

Test Plan:
1. Reset release with memory latency L=1 and if_ready=1: req addrs 0,4,8,...; if_pc=0 at cycle 3 with inst from mem[0]; thereafter one instruction per cycle.
2. if_ready=0, DEPTH=4, MAX_OUTSTANDING=2: exactly 4 words queued, then imem_req_valid=0. Releasing if_ready gives if_pc 0,4,8,12 in order with no loss.
3. L=3, redirect_pc=0x100 while 2 requests are outstanding: both stale responses dropped; next if_pc=0x100, then 0x104; if_valid=0 the cycle after redirect.
4. Redirect in the same cycle as if_valid&if_ready and an imem response: no pop counted, response discarded, next delivered if_pc=redirect_pc.
5. redirect_pc=0x102: fetch_fault=1, imem_req_valid stays 0. Redirect to 0x200: fault clears, fetch resumes at 0x200.
6. req_pc=0xFFFF_FFFC: the next request address wraps to 0x0000_0000 and if_pc_plus4 of that instruction is 0x0. Asserting reset mid-burst clears the queue asynchronously and fetch restarts at RESET_PC.
